// File: rtl/serial_rx_if.sv
// Line-side and consumer-side signals of the 8N1 receiver.
// The master is the host (drives the line and the ack); the slave is the receiver.
interface serial_rx_if;
    logic       serial_in;
    logic       rd_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output serial_in, rd_ack,
        input  data, data_valid, frame_err, overrun, busy
    );

    modport slave (
        input  serial_in, rd_ack,
        output data, data_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_rx.sv
// 8N1 serial receiver: byte valid 2+H+9N+1 cycles after the line falls; one-byte holding register.
// No backpressure on the line: a byte arriving while data_valid=1 without rd_ack is dropped and sets overrun.
module serial_rx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       sysclk,
    input  logic       reset,
    serial_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] TC_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] TC_BIT  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_tc;
    logic [7:0]       sr_q;
    logic [7:0]       data_q;
    logic             data_valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             busy_q;

    always_comb begin
        cnt_tc = (state_q == START) ? (cnt_q == TC_HALF) : (cnt_q == TC_BIT);
        cnt_d  = cnt_tc ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            sr_q         <= '0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q     <= bus.serial_in;
            rx_s_q      <= sync1_q;
            frame_err_q <= 1'b0;

            if (bus.rd_ack && data_valid_q) begin
                data_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (cnt_tc) begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            // Marker bit reaches bit 0 just before the eighth sample.
                            sr_q    <= 8'h80;
                        end
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (cnt_tc) begin
                        sr_q <= {rx_s_q, sr_q[7:1]};
                        if (sr_q[0]) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    if (cnt_tc) begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            // A same-cycle ack frees the register for the new byte.
                            if (!data_valid_q || bus.rd_ack) begin
                                data_q       <= sr_q;
                                data_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            state_q     <= WAIT_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 16 clocks per bit; F is the cycle the line is driven low, S = F+2.
module tb_serial_rx;

    localparam int N = 16;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   fe_cnt = 0;
    int   fe0;

    serial_rx_if rx_if ();

    serial_rx #(.CLKS_PER_BIT(N)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (rx_if.slave)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (rx_if.frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_if.serial_in = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 8; i++) begin
            rx_if.serial_in = b[i];
            wait_cyc(N);
        end
        rx_if.serial_in = stop_bit;
        wait_cyc(N);
        rx_if.serial_in = 1'b1;
    endtask

    task automatic ack_one();
        rx_if.rd_ack = 1'b1;
        wait_cyc(1);
        rx_if.rd_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rx_if.serial_in = 1'b1;
        rx_if.rd_ack    = 1'b0;
        reset           = 1'b1;
        wait_cyc(3);
        check("rst_data",  rx_if.data,       8'h00);
        check("rst_valid", rx_if.data_valid, 1'b0);
        check("rst_ferr",  rx_if.frame_err,  1'b0);
        check("rst_ovr",   rx_if.overrun,    1'b0);
        check("rst_busy",  rx_if.busy,       1'b0);
        reset = 1'b0;
        wait_cyc(4);

        // Stop bit low: framing error only, register untouched
        fe0 = fe_cnt;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                wait_cyc(155);
                check("ferr_pulse", rx_if.frame_err,  1'b1);
                check("ferr_valid", rx_if.data_valid, 1'b0);
                check("ferr_data",  rx_if.data,       8'h00);
                wait_cyc(1);
                check("ferr_end",   rx_if.frame_err,  1'b0);
            end
        join
        check("ferr_count", fe_cnt - fe0, 1);
        wait_cyc(4);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                wait_cyc(155);
                check("after_ferr_data",  rx_if.data,       8'h5A);
                check("after_ferr_valid", rx_if.data_valid, 1'b1);
            end
        join
        ack_one();
        check("ack_5a_valid", rx_if.data_valid, 1'b0);
        wait_cyc(4);

        // Plain valid frame and latency
        fe0 = fe_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_cyc(52);
                check("a5_busy_mid",  rx_if.busy,       1'b1);
                wait_cyc(102);
                check("a5_early",     rx_if.data_valid, 1'b0);
                wait_cyc(1);
                check("a5_data",      rx_if.data,       8'hA5);
                check("a5_valid",     rx_if.data_valid, 1'b1);
                check("a5_ferr",      rx_if.frame_err,  1'b0);
                check("a5_ovr",       rx_if.overrun,    1'b0);
                check("a5_busy_done", rx_if.busy,       1'b0);
            end
        join
        check("a5_ferr_count", fe_cnt - fe0, 0);
        ack_one();
        check("ack_a5_valid", rx_if.data_valid, 1'b0);
        check("ack_a5_data",  rx_if.data,       8'hA5);
        wait_cyc(4);

        // Three-cycle glitch is rejected at the half-bit sample
        fe0 = fe_cnt;
        rx_if.serial_in = 1'b0;
        fork
            begin
                wait_cyc(3);
                rx_if.serial_in = 1'b1;
            end
            begin
                wait_cyc(6);
                check("glitch_busy_start", rx_if.busy, 1'b1);
                wait_cyc(5);
                check("glitch_busy_off",   rx_if.busy, 1'b0);
            end
        join
        wait_cyc(200);
        check("glitch_valid", rx_if.data_valid, 1'b0);
        check("glitch_ferr",  fe_cnt - fe0,     0);

        // Back-to-back frames without ack: second byte dropped
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                wait_cyc(155);
                check("b2b_first_data", rx_if.data,       8'h11);
                wait_cyc(160);
                check("ovr_data",       rx_if.data,       8'h11);
                check("ovr_valid",      rx_if.data_valid, 1'b1);
                check("ovr_flag",       rx_if.overrun,    1'b1);
            end
        join
        ack_one();
        check("ovr_ack_valid", rx_if.data_valid, 1'b0);
        check("ovr_ack_flag",  rx_if.overrun,    1'b0);
        wait_cyc(4);

        // Ack in the exact acceptance cycle of the second byte
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                wait_cyc(155);
                check("same_first_valid", rx_if.data_valid, 1'b1);
                wait_cyc(159);
                rx_if.rd_ack = 1'b1;
                check("same_pre_data", rx_if.data, 8'h11);
                wait_cyc(1);
                rx_if.rd_ack = 1'b0;
                check("same_data",  rx_if.data,       8'h22);
                check("same_valid", rx_if.data_valid, 1'b1);
                check("same_ovr",   rx_if.overrun,    1'b0);
            end
        join
        wait_cyc(4);

        // Reset during data bit 4 of 0x77, held until the frame is over
        fe0 = fe_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_cyc(88);
                reset = 1'b1;
                #1;
                check("mid_rst_data",  rx_if.data,       8'h00);
                check("mid_rst_valid", rx_if.data_valid, 1'b0);
                check("mid_rst_ferr",  rx_if.frame_err,  1'b0);
                check("mid_rst_ovr",   rx_if.overrun,    1'b0);
                check("mid_rst_busy",  rx_if.busy,       1'b0);
                wait_cyc(80);
                check("hold_rst_valid", rx_if.data_valid, 1'b0);
                check("hold_rst_busy",  rx_if.busy,       1'b0);
                reset = 1'b0;
            end
        join
        wait_cyc(4);
        fork
            send_frame(8'h9C, 1'b1);
            begin
                wait_cyc(155);
                check("post_rst_data",  rx_if.data,       8'h9C);
                check("post_rst_valid", rx_if.data_valid, 1'b1);
            end
        join
        check("post_rst_ferr", fe_cnt - fe0, 0);
        wait_cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
